// File: rtl/renderer_pkg.sv
// rtl/renderer_pkg.sv - shared renderer types and default frame geometry
// Contents:
//   DEF_H_RES / DEF_V_RES  default visible resolution, shared with the display reader
//   rgb565_t               packed RGB565 pixel {r[4:0], g[5:0], b[4:0]}
//   fb_state_t             frame buffer writer states {CLEAR, RUN, DRAIN}
package renderer_pkg;

    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 180;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN
    } fb_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - two-stage pipelined linear address y*H_RES+x with bounds flag
// Ports:
//   clk_in, rst_n_in     clock, asynchronous active-low reset
//   valid_in             pixel enters stage 1 this cycle
//   x_in, y_in, color_in pixel coordinates and colour
//   valid_out            stage 2 holds a pixel
//   in_bounds_out        x<H_RES && y<V_RES for the stage 2 pixel
//   last_out             stage 2 pixel is in bounds and lands on address H_RES*V_RES-1
//   addr_out, color_out  stage 2 address and colour
//   occupied_out         either stage holds a pixel
module fb_addr_calc
    import renderer_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    input  logic [10:0]       x_in,
    input  logic [9:0]        y_in,
    input  rgb565_t           color_in,
    output logic              valid_out,
    output logic              in_bounds_out,
    output logic              last_out,
    output logic [ADDR_W-1:0] addr_out,
    output rgb565_t           color_out,
    output logic              occupied_out
);

    // Wide enough for 1023*H_RES + 2047 at any sensible resolution, so an
    // out-of-range pixel never aliases onto the last address.
    localparam int FULL_W = 22;

    logic              s1_valid;
    logic [10:0]       s1_x;
    logic [9:0]        s1_y;
    logic [FULL_W-1:0] s1_row;
    rgb565_t           s1_color;
    logic [FULL_W-1:0] addr_full;
    logic              s1_in_bounds;

    assign addr_full    = s1_row + FULL_W'(s1_x);
    assign s1_in_bounds = (s1_x < 11'(H_RES)) && (s1_y < 10'(V_RES));
    assign occupied_out = s1_valid || valid_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid      <= 1'b0;
            s1_x          <= '0;
            s1_y          <= '0;
            s1_row        <= '0;
            s1_color      <= '0;
            valid_out     <= 1'b0;
            in_bounds_out <= 1'b0;
            last_out      <= 1'b0;
            addr_out      <= '0;
            color_out     <= '0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_x     <= x_in;
                s1_y     <= y_in;
                s1_row   <= FULL_W'(y_in) * FULL_W'(H_RES);
                s1_color <= color_in;
            end
            valid_out     <= s1_valid;
            in_bounds_out <= s1_in_bounds;
            last_out      <= s1_in_bounds && (addr_full == FULL_W'(H_RES * V_RES - 1));
            addr_out      <= addr_full[ADDR_W-1:0];
            color_out     <= s1_color;
        end
    end

endmodule

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - pixel stream to BRAM write port with optional clear engine
// Configuration: FB_CLEAR_EN enables the CLEAR/DRAIN states and honours clear_in.
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   pixel_valid_in/ready_out  pixel handshake; x_in, y_in, r_in, g_in, b_in carry the pixel
//   clear_in                  pulse requesting a background fill
//   wr_en_out, wr_addr_out,   BRAM write port, data is RGB565
//   wr_data_out
//   busy_out                  clear pending or in progress
//   frame_done_out            pulse with the write to address H_RES*V_RES-1
//   drop_count_out            saturating count of out-of-bounds pixels
module frame_buffer_writer
    import renderer_pkg::*;
#(
    parameter int          H_RES    = DEF_H_RES,
    parameter int          V_RES    = DEF_V_RES,
    parameter int          ADDR_W   = $clog2(H_RES * V_RES),
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              pixel_valid_in,
    output logic              pixel_ready_out,
    input  logic [10:0]       x_in,
    input  logic [9:0]        y_in,
    input  logic [4:0]        r_in,
    input  logic [5:0]        g_in,
    input  logic [4:0]        b_in,
    input  logic              clear_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [15:0]       wr_data_out,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic [15:0]       drop_count_out
);

    localparam int LAST_ADDR = H_RES * V_RES - 1;
`ifdef FB_CLEAR_EN
    localparam fb_state_t RESET_STATE = CLEAR;
`else
    localparam fb_state_t RESET_STATE = RUN;
`endif

    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              busy_q;
    logic              live_q;
    logic              accept;
    rgb565_t           pix_color;
    logic              s2_valid, s2_in_bounds, s2_last, pipe_occupied;
    logic [ADDR_W-1:0] s2_addr;
    rgb565_t           s2_color;

    assign pix_color = '{r: r_in, g: g_in, b: b_in};
    // busy_q also covers the cycle in which the last clear write sits on the
    // output register, so a pixel is never accepted while a clear is visible.
    // live_q keeps ready low while reset is asserted.
    assign pixel_ready_out = live_q && (state_q == RUN) && !busy_q;
    assign accept          = pixel_valid_in && pixel_ready_out;

`ifdef FB_CLEAR_EN
    assign busy_out = busy_q;
`else
    assign busy_out = 1'b0;
    logic unused_cfg;
    assign unused_cfg = clear_in ^ busy_q;
`endif

    fb_addr_calc #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .ADDR_W(ADDR_W)
    ) u_addr_calc (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (accept),
        .x_in         (x_in),
        .y_in         (y_in),
        .color_in     (pix_color),
        .valid_out    (s2_valid),
        .in_bounds_out(s2_in_bounds),
        .last_out     (s2_last),
        .addr_out     (s2_addr),
        .color_out    (s2_color),
        .occupied_out (pipe_occupied)
    );

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
`ifdef FB_CLEAR_EN
        case (state_q)
            RUN: begin
                if (clear_in && !busy_q) state_d = DRAIN;
            end
            DRAIN: begin
                // S3 is the output register; wr_en_out only carries pixel writes here.
                if (!pipe_occupied && !wr_en_out) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_addr_q == ADDR_W'(LAST_ADDR)) state_d = RUN;
                else clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
            default: state_d = RUN;
        endcase
`else
        state_d = RUN;
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= RESET_STATE;
            clr_addr_q     <= '0;
            busy_q         <= 1'b0;
            live_q         <= 1'b0;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            frame_done_out <= 1'b0;
            drop_count_out <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            live_q     <= 1'b1;
            busy_q     <= (state_d != RUN) || (state_q == CLEAR);
            if (state_q == CLEAR) begin
                wr_en_out      <= 1'b1;
                wr_addr_out    <= clr_addr_q;
                wr_data_out    <= BG_COLOR;
                frame_done_out <= 1'b0;
            end else begin
                wr_en_out      <= s2_valid && s2_in_bounds;
                wr_addr_out    <= s2_addr;
                wr_data_out    <= s2_color;
                frame_done_out <= s2_valid && s2_last;
            end
            if (s2_valid && !s2_in_bounds && (drop_count_out != 16'hFFFF))
                drop_count_out <= drop_count_out + 16'd1;
        end
    end

endmodule
